mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the single-ported unified memory between the instruction-fetch path and the load/store path of the KLP32 core. The block accepts one request at a time and registers its payload. It then drives the shared memory port until the memory acknowledges, and returns read data to the winner with a one-cycle done pulse. The data side has fixed priority; an optional anti-starvation guard bounds how long fetch can be locked out.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `STARVE_MAX`, default 4: maximum number of consecutive data grants while fetch is waiting. Valid range is 1–15. Used only with the guard macro.

Ports. One clock; reset is asynchronous and active-low.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `if_req` in 1: fetch request. Held with a stable `if_addr` until `if_done`.
- `if_addr` in ADDR_W: fetch address.
- `if_done` out 1: one-cycle pulse; fetch complete.
- `if_rdata` out DATA_W: fetched word. Valid while `if_done` is high.
- `d_req` in 1: data request. Held with a stable payload until `d_done`.
- `d_we` in 1: 1 selects store, 0 selects load. Same sense as MemRw.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: store data.
- `d_wstrb` in 4: byte strobes for the store.
- `d_done` out 1: one-cycle pulse; access complete.
- `d_rdata` out DATA_W: load data. Valid while `d_done` is high.
- `mem_req` out 1: memory request. Held until `mem_ack`.
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb` out: registered payload. Stable while `mem_req` is high.
- `mem_ack` in 1: memory completion. Sampled only while `mem_req` is high.
- `mem_rdata` in DATA_W: read data. Valid with `mem_ack`.
- `busy` out 1: high in every state except IDLE.

## Operation
- The FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise pick a winner, latch its payload into the `mem_*` registers and a `owner` flop (0 = fetch, 1 = data), and go to ACCESS.
  - For fetch, the latched values are `mem_we=0` and `mem_wstrb=0`.
- Winner selection:
  - If `d_req` is high, data wins.
  - Otherwise, if `if_req` is high, fetch wins.
  - When the guard override is active, fetch wins instead (see Configuration).
- ACCESS:
  - `mem_req` is 1.
  - On `mem_ack`, capture `mem_rdata` into the response register and go to RESP.
  - With no ack, stay in ACCESS indefinitely. There is no timeout.
- RESP:
  - Assert `if_done` or `d_done` for exactly one cycle, according to `owner`.
  - `mem_req` is 0.
  - Requests are ignored in this state.
  - Next state is always IDLE.
- `if_rdata` and `d_rdata` both present the response register. Each is meaningful only while its own done signal is high.
- For a store, the response register still captures `mem_rdata`. Its content is don't-care.
- Requesters must drop `req` in the cycle after done, or present a new payload. A request still high when the FSM reaches IDLE is treated as a new request.
- A requester deasserting `req` before done is a protocol violation; the arbiter completes the latched transaction regardless.

## Timing
- Reset values: state IDLE, `owner`=0, `mem_req`=0, `mem_*` payload=0, `if_done`=`d_done`=0, response register=0, `busy`=0, starve counter=0.
- Reset asserted mid-operation: return to IDLE immediately and drop `mem_req` asynchronously. The transaction is abandoned and no done pulse is issued.
- Cycle-level sequence:
  - Cycle 0: request sampled in IDLE.
  - Cycle 1: `mem_req` is high.
  - Ack arrives in cycle k (k ≥ 1).
  - Cycle k+1: done is high.
- Minimum request-to-done latency is 2 cycles.
- Back-to-back transactions need at least 3 cycles each: IDLE, ACCESS, RESP.
- Both requests high in IDLE: exactly one is granted. The loser stays pending and is re-evaluated at the next IDLE.
- Done outputs are registered, with no combinational path from `mem_ack`.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - A 4-bit starve counter increments on each data grant made while `if_req` is high.
  - The counter clears on any fetch grant.
  - The counter also clears on any data grant made while `if_req` is low.
  - When the counter equals `STARVE_MAX` and both requests are high, fetch wins.
- `ARB_STARVE_GUARD_EN` undefined:
  - The counter logic is absent.
  - Priority is strictly data over fetch, and fetch may starve indefinitely.

## Test plan
- Reset, then fetch only: `if_addr`=0x00000010, memory acks 1 cycle after `mem_req` with 0x00400793. Required: `mem_req` high in cycle 1 with `mem_addr`=0x10 and `mem_we`=0; `if_done` high in cycle 2 with `if_rdata`=0x00400793; `d_done` never high.
- Store: `d_we`=1, `d_addr`=0x0FEC, `d_wdata`=0xDEADBEEF, `d_wstrb`=4'hF. Required: `mem_we`=1 and the payload matches the inputs; `d_done` pulses one cycle after `mem_ack`.
- Both requests raised in the same IDLE cycle. Required: data granted first; fetch granted at the next IDLE; exactly one done per transaction.
- Ack delayed 5 cycles. Required: `mem_req` and payload stable for all 5 cycles; done 1 cycle after ack; `busy`=1 throughout.
- `rst_n` pulled low while in ACCESS. Required: `mem_req`=0 immediately; no done pulse; the next transaction behaves normally.
- Guard enabled, `STARVE_MAX`=4, `d_req` and `if_req` held high continuously. Required: grant order D, D, D, D, F, D, and so on. Guard disabled: fetch is never granted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-ported unified memory between the
// instruction-fetch path and the load/store path. One transaction at a time:
// IDLE picks a winner and registers its payload, ACCESS drives the memory
// port until mem_ack, RESP pulses the winner's done for one cycle.
// Data has fixed priority over fetch.
// Optional macro ARB_STARVE_GUARD_EN: after STARVE_MAX consecutive data
// grants with fetch waiting, the next contested grant goes to fetch.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // fetch side
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    // load/store side
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    // shared memory port
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("mem_port_arbiter: STARVE_MAX must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              grant_any;      // a request is accepted this cycle
    logic              grant_data;     // ... and it is the data side
    logic              fetch_override; // guard forces fetch to win
    logic              owner;          // 0 = fetch, 1 = data
    logic [DATA_W-1:0] resp_q;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;

    // Fetch takes a contested grant once data has won STARVE_MAX times in a row.
    assign fetch_override = (starve_cnt == STARVE_LIM) && if_req;

    // Count data grants made while fetch is waiting; any other grant clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (grant_any) begin
            if (grant_data && if_req) begin
                starve_cnt <= starve_cnt + 4'd1;
            end else begin
                starve_cnt <= 4'd0;
            end
        end
    end
`else
    assign fetch_override = 1'b0;
`endif

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and grant decision.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        state_nxt  = state;
        grant_any  = 1'b0;
        grant_data = 1'b0;
        case (state)
            IDLE: begin
                if (d_req || if_req) begin
                    grant_any  = 1'b1;
                    grant_data = d_req && !fetch_override;
                    state_nxt  = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Payload, owner, response capture and registered done pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= 4'd0;
            resp_q    <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            if (grant_any) begin
                owner <= grant_data;
                if (grant_data) begin
                    mem_we    <= d_we;
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                    mem_wstrb <= d_wstrb;
                end else begin
                    mem_we    <= 1'b0;
                    mem_addr  <= if_addr;
                    mem_wdata <= '0;
                    mem_wstrb <= 4'd0;
                end
            end
            if (state == ACCESS && mem_ack) begin
                resp_q  <= mem_rdata;
                if_done <= !owner;
                d_done  <= owner;
            end
        end
    end

    // mem_req decodes the state flop, so reset drops it asynchronously.
    assign mem_req  = (state == ACCESS);
    assign busy     = (state != IDLE);
    assign if_rdata = resp_q;
    assign d_rdata  = resp_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. Inputs change and outputs
// are sampled 1 ns after the rising edge.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_wstrb;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_wstrb  (d_wstrb),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requests are already driven while the DUT sits in IDLE. Runs one full
    // IDLE->ACCESS->RESP->IDLE sequence with the ack arriving after 'delay'
    // extra ACCESS cycles, checking payload stability, done pulse and data.
    task automatic run_access(input string tag, input int delay,
                              input logic [31:0] rdata, input logic exp_owner,
                              input logic exp_we, input logic [31:0] exp_addr,
                              input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                              input logic keep_req);
        tick();
        for (int i = 0; i <= delay; i++) begin
            if (i == delay) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
            check({tag, ".mem_req"}, 32'(mem_req), 32'd1);
            check({tag, ".mem_addr"}, mem_addr, exp_addr);
            check({tag, ".mem_we"}, 32'(mem_we), 32'(exp_we));
            check({tag, ".mem_wstrb"}, 32'(mem_wstrb), 32'(exp_wstrb));
            if (exp_we) check({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
            check({tag, ".busy_acc"}, 32'(busy), 32'd1);
            check({tag, ".no_done_acc"}, 32'({if_done, d_done}), 32'd0);
            tick();
        end
        mem_ack   = 1'b0;
        mem_rdata = 32'hA5A5_0000;
        check({tag, ".if_done"}, 32'(if_done), 32'(!exp_owner));
        check({tag, ".d_done"}, 32'(d_done), 32'(exp_owner));
        check({tag, ".mem_req_resp"}, 32'(mem_req), 32'd0);
        check({tag, ".busy_resp"}, 32'(busy), 32'd1);
        if (!exp_we) check({tag, ".rdata"}, exp_owner ? d_rdata : if_rdata, rdata);
        if (!keep_req) begin
            if (exp_owner) d_req = 1'b0;
            else if_req = 1'b0;
        end
        tick();
        check({tag, ".done_cleared"}, 32'({if_done, d_done}), 32'd0);
        check({tag, ".idle"}, 32'({busy, mem_req}), 32'd0);
    endtask

    logic exp_fetch;

    initial begin
        rst_n     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_wstrb   = 4'd0;
        mem_ack   = 1'b0;
        mem_rdata = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst.mem_req", 32'(mem_req), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'({if_done, d_done}), 32'd0);
        check("rst.mem_addr", mem_addr, 32'd0);
        check("rst.payload", 32'({mem_we, mem_wstrb}), 32'd0);
        check("rst.rdata", if_rdata, 32'd0);
        rst_n = 1'b1;
        tick();

        // Fetch only, ack in first ACCESS cycle
        if_req  = 1'b1;
        if_addr = 32'h0000_0010;
        run_access("fetch", 0, 32'h0040_0793, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);

        // Store
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0FEC;
        d_wdata = 32'hDEAD_BEEF;
        d_wstrb = 4'hF;
        run_access("store", 0, 32'h1111_2222, 1'b1, 1'b1, 32'hFEC, 32'hDEAD_BEEF, 4'hF, 1'b0);

        // Both requests in the same IDLE cycle: data first, then fetch
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h0000_0200;
        d_wstrb = 4'h0;
        if_req  = 1'b1;
        if_addr = 32'h0000_0300;
        run_access("both.d", 0, 32'hCAFE_0001, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 1'b0);
        run_access("both.f", 0, 32'hCAFE_0002, 1'b0, 1'b0, 32'h300, 32'h0, 4'h0, 1'b0);

        // Ack delayed 5 cycles (load)
        d_req  = 1'b1;
        d_addr = 32'h0000_0444;
        run_access("slow", 5, 32'h7654_3210, 1'b1, 1'b0, 32'h444, 32'h0, 4'h0, 1'b0);

        // Reset pulled in ACCESS: mem_req drops at once, no done
        d_req  = 1'b1;
        d_addr = 32'h0000_0555;
        tick();
        check("rstmid.mem_req_before", 32'(mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid.mem_req_async", 32'(mem_req), 32'd0);
        check("rstmid.busy_async", 32'(busy), 32'd0);
        d_req   = 1'b0;
        mem_ack = 1'b1;
        tick();
        check("rstmid.no_done", 32'({if_done, d_done}), 32'd0);
        mem_ack = 1'b0;
        rst_n   = 1'b1;
        tick();
        if_req  = 1'b1;
        if_addr = 32'h0000_0660;
        run_access("after_rst", 1, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h660, 32'h0, 4'h0, 1'b0);

        // Both requests held high: grant order depends on the guard
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h0000_0700;
        if_req  = 1'b1;
        if_addr = 32'h0000_0800;
        for (int i = 0; i < 7; i++) begin
`ifdef ARB_STARVE_GUARD_EN
            exp_fetch = (i == 4);
`else
            exp_fetch = 1'b0;
`endif
            run_access($sformatf("starve%0d", i), 0, 32'h5000_0000 + 32'(i),
                       !exp_fetch, 1'b0, exp_fetch ? 32'h800 : 32'h700,
                       32'h0, 4'h0, 1'b1);
        end
        d_req  = 1'b0;
        if_req = 1'b0;
        tick();
        check("end.idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
